// File: rtl/tlb_mgr.sv
// tlb_mgr: sequences TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB against the TLB and returns CSR write-back strobes.
module tlb_mgr #(
  parameter int TLBNUM = 16,
  parameter int IDXW = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [2:0]      op_code,
  input  logic [4:0]      inv_op,
  input  logic [9:0]      inv_asid,
  input  logic [31:0]     inv_va,
  input  logic [9:0]      csr_asid,
  input  logic [18:0]     csr_ehi_vppn,
  input  logic [IDXW-1:0] csr_idx,
  input  logic            csr_ne,
  input  logic            csr_tlbr,
  input  logic [88:0]     csr_entry,
  output logic            done_valid,
  output logic [2:0]      done_op,
  output logic            done_err,
  output logic            srch_we,
  output logic            srch_hit,
  output logic [IDXW-1:0] srch_index,
  output logic            rd_we,
  output logic [88:0]     rd_entry,
  input  logic [18:0]     mem_vppn,
  input  logic            mem_va_bit12,
  input  logic [9:0]      mem_asid,
  output logic [18:0]     tlb_s1_vppn,
  output logic            tlb_s1_va_bit12,
  output logic [9:0]      tlb_s1_asid,
  input  logic            tlb_s1_found,
  input  logic [IDXW-1:0] tlb_s1_index,
  output logic            tlb_invtlb_valid,
  output logic [4:0]      tlb_invtlb_op,
  output logic            tlb_we,
  output logic [IDXW-1:0] tlb_w_index,
  output logic [88:0]     tlb_w_entry,
  output logic [IDXW-1:0] tlb_r_index,
  input  logic [88:0]     tlb_r_entry
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic [2:0]      op_q;
  logic [4:0]      inv_op_q;
  logic [9:0]      inv_asid_q;
  logic [18:0]     inv_vppn_q;
  logic [IDXW-1:0] fill_cnt, fill_q;
  logic exec, resp, is_srch, is_rd, is_wr, is_fill, is_inv, inv_ok, err, msel;
  logic unused;
  assign unused = ^{inv_va[12:0], csr_entry[88]};
  always_comb begin
    state_nx = state == IDLE ? (op_valid ? EXEC : IDLE) : state == EXEC ? RESP : IDLE;
  end
  assign op_ready = state == IDLE;
  assign exec     = state == EXEC;
  assign resp     = state == RESP;
  assign is_srch  = op_q == 3'd1;
  assign is_rd    = op_q == 3'd2;
  assign is_wr    = op_q == 3'd3;
  assign is_fill  = op_q == 3'd4;
  assign is_inv   = op_q == 3'd5;
  assign inv_ok   = inv_op_q <= 5'd6;
  assign err      = op_q == 3'd0 || op_q > 3'd5 || (is_inv && !inv_ok);
  assign done_valid = resp;
  assign done_op    = resp ? op_q : 3'd0;
  assign done_err   = resp & err;
  assign srch_we    = resp & is_srch;
  assign rd_we      = resp & is_rd;
  assign tlb_we           = exec & (is_wr | is_fill);
  assign tlb_w_index      = is_fill ? fill_q : csr_idx;
  assign tlb_w_entry      = {csr_tlbr | ~csr_ne, csr_entry[87:0]};
  assign tlb_r_index      = csr_idx;
  assign tlb_invtlb_valid = exec & is_inv & inv_ok;
  assign tlb_invtlb_op    = inv_op_q;
  // Search port 1 is borrowed from the data side only while a management lookup executes
  assign msel            = exec & (is_srch | is_inv);
  assign tlb_s1_vppn     = msel ? (is_srch ? csr_ehi_vppn : inv_vppn_q) : mem_vppn;
  assign tlb_s1_va_bit12 = msel ? 1'b0 : mem_va_bit12;
  assign tlb_s1_asid     = msel ? (is_srch ? csr_asid : inv_asid_q) : mem_asid;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      op_q       <= '0;
      inv_op_q   <= '0;
      inv_asid_q <= '0;
      inv_vppn_q <= '0;
      fill_cnt   <= '0;
      fill_q     <= '0;
      srch_hit   <= 1'b0;
      srch_index <= '0;
      rd_entry   <= '0;
    end else begin
      state    <= state_nx;
      fill_cnt <= fill_cnt == IDXW'(TLBNUM - 1) ? '0 : fill_cnt + 1'b1;
      if (op_valid && op_ready) begin
        op_q       <= op_code;
        inv_op_q   <= inv_op;
        inv_asid_q <= inv_asid;
        inv_vppn_q <= inv_va[31:13];
        fill_q     <= fill_cnt;
      end
      if (exec && is_srch) begin
        srch_hit   <= tlb_s1_found;
        srch_index <= tlb_s1_found ? tlb_s1_index : '0;
      end
      if (exec && is_rd) rd_entry <= tlb_r_entry[88] ? tlb_r_entry : '0;
    end
  end
endmodule

// File: tb/tb_tlb_mgr.sv
// tb_tlb_mgr: vector table plus hand sequences against tlb_mgr with a small behavioural TLB stub.
module tb_tlb_mgr;
  logic clk = 1'b0, resetn = 1'b0;
  always #5 clk = ~clk;
  logic op_valid = 1'b0, op_ready;
  logic [2:0] op_code = '0;
  logic [4:0] inv_op = '0;
  logic [9:0] inv_asid = '0, csr_asid = '0;
  logic [31:0] inv_va = '0;
  logic [18:0] csr_ehi_vppn = '0;
  logic [3:0] csr_idx = '0;
  logic csr_ne = 1'b0, csr_tlbr = 1'b0;
  logic [88:0] csr_entry = '0;
  logic done_valid, done_err, srch_we, srch_hit, rd_we;
  logic [2:0] done_op;
  logic [3:0] srch_index;
  logic [88:0] rd_entry;
  logic [18:0] mem_vppn = 19'h7ABCD;
  logic mem_va_bit12 = 1'b1;
  logic [9:0] mem_asid = 10'h2AA;
  logic [18:0] tlb_s1_vppn;
  logic tlb_s1_va_bit12, tlb_s1_found, tlb_invtlb_valid, tlb_we;
  logic [9:0] tlb_s1_asid;
  logic [3:0] tlb_s1_index, tlb_w_index, tlb_r_index;
  logic [4:0] tlb_invtlb_op;
  logic [88:0] tlb_w_entry, tlb_r_entry;

  tlb_mgr dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .inv_op(inv_op), .inv_asid(inv_asid), .inv_va(inv_va), .csr_asid(csr_asid),
    .csr_ehi_vppn(csr_ehi_vppn), .csr_idx(csr_idx), .csr_ne(csr_ne), .csr_tlbr(csr_tlbr),
    .csr_entry(csr_entry), .done_valid(done_valid), .done_op(done_op), .done_err(done_err),
    .srch_we(srch_we), .srch_hit(srch_hit), .srch_index(srch_index), .rd_we(rd_we),
    .rd_entry(rd_entry), .mem_vppn(mem_vppn), .mem_va_bit12(mem_va_bit12), .mem_asid(mem_asid),
    .tlb_s1_vppn(tlb_s1_vppn), .tlb_s1_va_bit12(tlb_s1_va_bit12), .tlb_s1_asid(tlb_s1_asid),
    .tlb_s1_found(tlb_s1_found), .tlb_s1_index(tlb_s1_index), .tlb_invtlb_valid(tlb_invtlb_valid),
    .tlb_invtlb_op(tlb_invtlb_op), .tlb_we(tlb_we), .tlb_w_index(tlb_w_index),
    .tlb_w_entry(tlb_w_entry), .tlb_r_index(tlb_r_index), .tlb_r_entry(tlb_r_entry)
  );

  // TLB stub: written by the DUT, searched on port 1 (exact vppn, global or asid match)
  logic [88:0] tlbm [16];
  always @(posedge clk) begin
    if (!resetn) for (int i = 0; i < 16; i++) tlbm[i] <= '0;
    else if (tlb_we) tlbm[tlb_w_index] <= tlb_w_entry;
  end
  always_comb begin
    tlb_s1_found = 1'b0;
    tlb_s1_index = '0;
    for (int i = 0; i < 16; i++)
      if (!tlb_s1_found && tlbm[i][88] && tlbm[i][87:69] == tlb_s1_vppn &&
          (tlbm[i][52] || tlbm[i][62:53] == tlb_s1_asid)) begin
        tlb_s1_found = 1'b1;
        tlb_s1_index = 4'(i);
      end
  end
  assign tlb_r_entry = tlbm[tlb_r_index];

  logic [3:0] fc;
  always @(posedge clk or negedge resetn) fc <= !resetn ? 4'd0 : fc + 4'd1;

  int checks = 0, fails = 0;
  task automatic chk(input string nm, input logic [88:0] act, input logic [88:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct { logic [2:0] op; logic err; logic hit; logic [3:0] sidx; logic [88:0] rd; } exp_t;
  exp_t sb[$];
  exp_t e;
  always @(negedge clk) begin
    if (resetn && done_valid) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: got done_op %0d expected no completion", done_op);
      end else begin
        e = sb.pop_front();
        chk("done_op", 89'(done_op), 89'(e.op));
        chk("done_err", 89'(done_err), 89'(e.err));
        chk("srch_we", 89'(srch_we), 89'(e.op == 3'd1));
        chk("rd_we", 89'(rd_we), 89'(e.op == 3'd2));
        chk("resp_strobes", 89'({tlb_we, tlb_invtlb_valid}), 89'(0));
        if (e.op == 3'd1) begin
          chk("srch_hit", 89'(srch_hit), 89'(e.hit));
          chk("srch_index", 89'(srch_index), 89'(e.sidx));
        end
        if (e.op == 3'd2) chk("rd_entry", rd_entry, e.rd);
      end
    end
  end

  typedef struct {
    logic [2:0] op; logic [4:0] iop; logic [9:0] iasid; logic [31:0] iva;
    logic [9:0] asid; logic [18:0] vppn; logic [3:0] idx; logic ne; logic tlbr;
    logic [88:0] ent; logic err; logic hit; logic [3:0] sidx;
  } vec_t;

  function automatic logic [88:0] mk(input logic ebit, input logic [18:0] vp, input logic [9:0] as, input logic g);
    return {ebit, vp, 6'd12, as, g, 26'h1234567 ^ {7'b0, vp}, 26'h0ABCDEF};
  endfunction

  logic [88:0] emem [16];

  task automatic wait_ready();
    int n = 0;
    while (!op_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!op_ready) chk("ready_timeout", 89'(op_ready), 89'(1));
  endtask

  // Issue one op from an aligned negedge, queue its completion, check the EXEC cycle
  task automatic run_op(input vec_t v);
    logic [3:0] fidx, widx;
    logic ebit, wr, inv;
    logic [29:0] s1x;
    exp_t x;
    wait_ready();
    op_code = v.op; inv_op = v.iop; inv_asid = v.iasid; inv_va = v.iva;
    csr_asid = v.asid; csr_ehi_vppn = v.vppn; csr_idx = v.idx; csr_ne = v.ne;
    csr_tlbr = v.tlbr; csr_entry = v.ent; op_valid = 1'b1;
    fidx = fc;
    chk("idle_s1_passthru", 89'({tlb_s1_vppn, tlb_s1_va_bit12, tlb_s1_asid}), 89'({mem_vppn, mem_va_bit12, mem_asid}));
    @(posedge clk);
    #1 op_valid = 1'b0;
    ebit = v.tlbr ? 1'b1 : ~v.ne;
    wr = v.op == 3'd3 || v.op == 3'd4;
    inv = v.op == 3'd5 && v.iop <= 5'd6;
    widx = v.op == 3'd4 ? fidx : v.idx;
    x.op = v.op; x.err = v.err; x.hit = v.hit; x.sidx = v.sidx;
    x.rd = emem[v.idx][88] ? emem[v.idx] : '0;
    sb.push_back(x);
    if (wr) emem[widx] = {ebit, v.ent[87:0]};
    s1x = v.op == 3'd1 ? {v.vppn, 1'b0, v.asid} : v.op == 3'd5 ? {v.iva[31:13], 1'b0, v.iasid} : {mem_vppn, mem_va_bit12, mem_asid};
    @(negedge clk);
    chk("exec_tlb_we", 89'(tlb_we), 89'(wr));
    chk("exec_invtlb_valid", 89'(tlb_invtlb_valid), 89'(inv));
    chk("exec_s1", 89'({tlb_s1_vppn, tlb_s1_va_bit12, tlb_s1_asid}), 89'(s1x));
    if (wr) begin
      chk("w_index", 89'(tlb_w_index), 89'(widx));
      chk("w_entry", tlb_w_entry, {ebit, v.ent[87:0]});
    end
    if (inv) chk("invtlb_op", 89'(tlb_invtlb_op), 89'(v.iop));
    if (v.op == 3'd2) chk("r_index", 89'(tlb_r_index), 89'(v.idx));
  endtask

  vec_t vt [13];
  vec_t fv;
  int acc [4];
  int na;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{3'd3, 5'd0, 10'd0, 32'h0, 10'd0, 19'h0, 4'd5, 1'b0, 1'b0, mk(1'b0, 19'h12345, 10'd3, 1'b0), 1'b0, 1'b0, 4'd0};
    vt[1]  = '{3'd1, 5'd0, 10'd0, 32'h0, 10'd3, 19'h12345, 4'd0, 1'b0, 1'b0, 89'h0, 1'b0, 1'b1, 4'd5};
    vt[2]  = '{3'd1, 5'd0, 10'd0, 32'h0, 10'd3, 19'h54321, 4'd0, 1'b0, 1'b0, 89'h0, 1'b0, 1'b0, 4'd0};
    vt[3]  = '{3'd3, 5'd0, 10'd0, 32'h0, 10'd0, 19'h0, 4'd9, 1'b0, 1'b0, mk(1'b0, 19'h0ABCD, 10'd7, 1'b1), 1'b0, 1'b0, 4'd0};
    vt[4]  = '{3'd2, 5'd0, 10'd0, 32'h0, 10'd0, 19'h0, 4'd9, 1'b0, 1'b0, 89'h0, 1'b0, 1'b0, 4'd0};
    vt[5]  = '{3'd3, 5'd0, 10'd0, 32'h0, 10'd0, 19'h0, 4'd9, 1'b1, 1'b1, mk(1'b0, 19'h33333, 10'd8, 1'b0), 1'b0, 1'b0, 4'd0};
    vt[6]  = '{3'd3, 5'd0, 10'd0, 32'h0, 10'd0, 19'h0, 4'd10, 1'b1, 1'b0, mk(1'b1, 19'h44444, 10'd9, 1'b0), 1'b0, 1'b0, 4'd0};
    vt[7]  = '{3'd2, 5'd0, 10'd0, 32'h0, 10'd0, 19'h0, 4'd10, 1'b0, 1'b0, 89'h0, 1'b0, 1'b0, 4'd0};
    vt[8]  = '{3'd2, 5'd0, 10'd0, 32'h0, 10'd0, 19'h0, 4'd9, 1'b0, 1'b0, 89'h0, 1'b0, 1'b0, 4'd0};
    vt[9]  = '{3'd5, 5'd5, 10'd3, 32'h2468A000, 10'd0, 19'h0, 4'd0, 1'b0, 1'b0, 89'h0, 1'b0, 1'b0, 4'd0};
    vt[10] = '{3'd5, 5'd9, 10'd3, 32'h2468A000, 10'd0, 19'h0, 4'd0, 1'b0, 1'b0, 89'h0, 1'b1, 1'b0, 4'd0};
    vt[11] = '{3'd7, 5'd0, 10'd0, 32'h0, 10'd0, 19'h0, 4'd0, 1'b0, 1'b0, 89'h0, 1'b1, 1'b0, 4'd0};
    vt[12] = '{3'd0, 5'd0, 10'd0, 32'h0, 10'd0, 19'h0, 4'd0, 1'b0, 1'b0, 89'h0, 1'b1, 1'b0, 4'd0};
    fv     = '{3'd4, 5'd0, 10'd0, 32'h0, 10'd0, 19'h0, 4'd0, 1'b0, 1'b0, mk(1'b0, 19'h60000, 10'd1, 1'b0), 1'b0, 1'b0, 4'd0};
    for (int i = 0; i < 16; i++) emem[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 89'(op_ready), 89'(1));
    chk("rst_strobes", 89'({done_valid, done_err, done_op, srch_we, rd_we, tlb_we, tlb_invtlb_valid}), 89'(0));
    chk("rst_results", 89'({srch_hit, srch_index}), 89'(0));
    chk("rst_rd_entry", rd_entry, 89'(0));
    resetn = 1'b1;
    for (int n = 0; n < 20 && fc != 4'd7; n++) @(negedge clk);
    chk("fill7_align", 89'(fc), 89'(7));
    run_op(fv);
    chk("fill_first_idx", 89'(tlb_w_index), 89'(7));
    for (int n = 0; n < 40 && fc != 4'd7; n++) @(negedge clk);
    run_op(fv);
    chk("fill_wrap_idx", 89'(tlb_w_index), 89'(7));
    for (int i = 0; i < 13; i++) run_op(vt[i]);
    wait_ready();
    op_code = 3'd1; csr_ehi_vppn = 19'h12345; csr_asid = 10'd3; op_valid = 1'b1;
    na = 0;
    for (int c = 0; c < 8; c++) begin
      if (op_ready) begin
        sb.push_back('{3'd1, 1'b0, 1'b1, 4'd5, 89'h0});
        if (na < 4) acc[na] = c;
        na++;
      end
      @(negedge clk);
    end
    op_valid = 1'b0;
    chk("b2b_accepts", 89'(na), 89'(3));
    chk("b2b_gap1", 89'(acc[1] - acc[0]), 89'(3));
    chk("b2b_gap2", 89'(acc[2] - acc[1]), 89'(3));
    wait_ready();
    op_code = 3'd3; csr_idx = 4'd3; csr_entry = mk(1'b0, 19'h55555, 10'd2, 1'b0); op_valid = 1'b1;
    @(posedge clk);
    #1 op_valid = 1'b0;
    @(negedge clk);
    chk("midrst_pre_we", 89'(tlb_we), 89'(1));
    resetn = 1'b0;
    #1;
    chk("midrst_ready", 89'(op_ready), 89'(1));
    chk("midrst_we", 89'(tlb_we), 89'(0));
    @(negedge clk);
    resetn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("midrst_no_done", 89'(done_valid), 89'(0));
    end
    chk("sb_empty", 89'(sb.size()), 89'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
